// File: rtl/fmap_bram_loader_pkg.sv
// Shared sizing constants and FSM state type for the feature-map BRAM loader.
// Bank count, word width and address width match the layer-04 DPRAM array.
package fmap_bram_loader_pkg;

   localparam int NUM_BANK = 16;
   localparam int DW       = 128;
   localparam int AW       = 9;
   localparam int CW       = 14;
   localparam int BANK_W   = $clog2(NUM_BANK);

   // Largest job that fills every bank exactly once.
   localparam logic [CW-1:0] MAX_WORDS = CW'(NUM_BANK * (2 ** AW));

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      DONE
   } loaderStateT;

endpackage

// File: rtl/fmap_bank_addr_gen.sv
// Word index, round-robin bank select and base-plus-row write address
// for the loader.
module fmap_bank_addr_gen
   import fmap_bram_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [AW-1:0]       baseAddr,
   input  logic                advance,
   output logic [CW-1:0]       wordIdx,
   output logic [NUM_BANK-1:0] bankSel,
   output logic [AW-1:0]       bankAddr
);

   logic [BANK_W-1:0] bankIdx;
   logic [AW-1:0]     rowIdx;
   logic [AW-1:0]     baseReg;

   // The row only advances once every bank has taken a word at this address.
   always_ff @(posedge clk) begin
      if (rst) begin
         wordIdx <= '0;
         bankIdx <= '0;
         rowIdx  <= '0;
         baseReg <= '0;
      end else if (clear) begin
         wordIdx <= '0;
         bankIdx <= '0;
         rowIdx  <= '0;
         baseReg <= baseAddr;
      end else if (advance) begin
         wordIdx <= wordIdx + CW'(1);
         if (bankIdx == BANK_W'(NUM_BANK - 1)) begin
            bankIdx <= '0;
            rowIdx  <= rowIdx + AW'(1);
         end else begin
            bankIdx <= bankIdx + BANK_W'(1);
         end
      end
   end

   // Address wraps modulo the bank depth by truncation.
   assign bankAddr = baseReg + rowIdx;

   always_comb begin
      bankSel = '0;
      for (int i = 0; i < NUM_BANK; i++) begin
         bankSel[i] = (bankIdx == BANK_W'(i));
      end
   end

endmodule

// File: rtl/fmap_bram_loader.sv
// Streams 128-bit words round-robin into the 16-bank feature-map DPRAM and
// pulses start to the parsing stage once the final write has landed.
module fmap_bram_loader
   import fmap_bram_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [CW-1:0]       i_num_words,
   input  logic [AW-1:0]       i_base_addr,
   input  logic                i_vld,
   input  logic [DW-1:0]       i_data,
   output logic                o_rdy,
   output logic [NUM_BANK-1:0] o_ena,
   output logic [NUM_BANK-1:0] o_wea,
   output logic [AW-1:0]       o_addra,
   output logic [DW-1:0]       o_dia,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_start
);

   loaderStateT         state;
   logic [CW-1:0]       lastIdx;
   logic [CW-1:0]       jobCount;
   logic [CW-1:0]       wordIdx;
   logic [NUM_BANK-1:0] bankSel;
   logic [AW-1:0]       bankAddr;
   logic                accept;
   logic                startJob;

   assign accept   = i_vld && o_rdy;
   assign jobCount = (i_num_words > MAX_WORDS) ? MAX_WORDS : i_num_words;
   assign startJob = (state == IDLE) && i_load && (i_num_words != '0);

   fmap_bank_addr_gen addrGen (
      .clk      (clk),
      .rst      (rst),
      .clear    (startJob),
      .baseAddr (i_base_addr),
      .advance  (accept),
      .wordIdx  (wordIdx),
      .bankSel  (bankSel),
      .bankAddr (bankAddr)
   );

   // Data and address are only captured on an accepted beat, so a stalled
   // stream never disturbs what the banks last saw.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lastIdx <= '0;
         o_rdy   <= 1'b0;
         o_ena   <= '0;
         o_wea   <= '0;
         o_addra <= '0;
         o_dia   <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_start <= 1'b0;
      end else begin
         o_ena   <= '0;
         o_wea   <= '0;
         o_done  <= 1'b0;
         o_start <= 1'b0;

         if (accept) begin
            o_ena   <= bankSel;
            o_wea   <= bankSel;
            o_addra <= bankAddr;
            o_dia   <= i_data;
         end

         case (state)
            IDLE: begin
               if (i_load) begin
                  o_busy <= 1'b1;
                  if (i_num_words == '0) begin
                     state <= DONE;
                  end else begin
                     lastIdx <= jobCount - CW'(1);
                     o_rdy   <= 1'b1;
                     state   <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (accept && (wordIdx == lastIdx)) begin
                  o_rdy <= 1'b0;
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               state <= DONE;
            end
            DONE: begin
               o_busy  <= 1'b0;
               o_done  <= 1'b1;
               o_start <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               o_rdy  <= 1'b0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fmap_bram_loader.sv
// Self-checking bench for fmap_bram_loader: table of load jobs checked against
// a bank/address model, plus hand sequences for reset, empty and ignored inputs.
module tb_fmap_bram_loader;
   import fmap_bram_loader_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic                i_load;
   logic [CW-1:0]       i_num_words;
   logic [AW-1:0]       i_base_addr;
   logic                i_vld;
   logic [DW-1:0]       i_data;
   logic                o_rdy;
   logic [NUM_BANK-1:0] o_ena;
   logic [NUM_BANK-1:0] o_wea;
   logic [AW-1:0]       o_addra;
   logic [DW-1:0]       o_dia;
   logic                o_busy;
   logic                o_done;
   logic                o_start;

   typedef struct {
      int bank;
      int addr;
      logic [DW-1:0] data;
   } writeRecT;

   typedef struct {
      int numWords;
      int base;
      int vldPct;
      int expWrites;
      int probeIdx;
      int probeBank;
      int probeAddr;
      int lastBank;
      int lastAddr;
      int expLatency;
   } jobVecT;

   writeRecT writeLog[$];
   int       strobeErrors = 0;
   int       testsRun = 0;
   int       failures = 0;

   fmap_bram_loader dut (
      .clk         (clk),
      .rst         (rst),
      .i_load      (i_load),
      .i_num_words (i_num_words),
      .i_base_addr (i_base_addr),
      .i_vld       (i_vld),
      .i_data      (i_data),
      .o_rdy       (o_rdy),
      .o_ena       (o_ena),
      .o_wea       (o_wea),
      .o_addra     (o_addra),
      .o_dia       (o_dia),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_start     (o_start)
   );

   always #5 clk = ~clk;

   // Record every bank write seen on the falling edge.
   always @(negedge clk) begin
      if (o_ena != '0) begin
         writeRecT rec;
         rec.bank = -1;
         for (int i = 0; i < NUM_BANK; i++) begin
            if (o_ena[i]) rec.bank = i;
         end
         rec.addr = int'(o_addra);
         rec.data = o_dia;
         writeLog.push_back(rec);
         if (o_wea !== o_ena || !$onehot(o_ena)) strobeErrors++;
      end
   end

   function automatic logic [DW-1:0] wordData(input int k);
      return {32'(k), 32'hC0DE_0000 + 32'(k), ~32'(k), 32'(k * 7)};
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      testsRun++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Run one job: returns cycles from the edge entering LOAD/DONE to o_start, or -1.
   task automatic applyStimulus(input int n, input int base, input int pct,
                                input int injectAt, output int latency);
      int  k;
      int  cyc;
      int  nEff;
      int  budget;
      bit  drove;
      bit  acc;
      nEff   = (n > int'(MAX_WORDS)) ? int'(MAX_WORDS) : n;
      budget = 4 * nEff + 50;
      writeLog.delete();
      strobeErrors = 0;
      @(posedge clk); #1;
      i_load      = 1'b1;
      i_num_words = CW'(n);
      i_base_addr = AW'(base);
      @(posedge clk); #1;
      i_load  = 1'b0;
      k       = 0;
      cyc     = 0;
      latency = -1;
      while (cyc < budget) begin
         if (o_start) begin
            latency = cyc;
            break;
         end
         drove  = (k < nEff) && ($urandom_range(99) < pct);
         i_vld  = drove;
         i_data = drove ? wordData(k) : {$urandom, $urandom, $urandom, $urandom};
         i_load = (cyc == injectAt);
         if (cyc == injectAt) i_num_words = CW'(3);
         acc = drove && o_rdy;
         @(posedge clk); #1;
         cyc++;
         if (acc) k++;
      end
      i_vld  = 1'b0;
      i_load = 1'b0;
   endtask

   initial begin
      jobVecT vec[5];
      int     lat;
      int     bad;
      int     sz;
      int     seen;
      int     starts;
      int     skew;

      vec[0] = '{32,   0,   100, 32,   17,   1, 1,   15, 1,   34};
      vec[1] = '{20,   511, 100, 20,   16,   0, 0,   3,  0,   22};
      vec[2] = '{48,   5,   50,  48,   20,   4, 6,   15, 7,   0};
      vec[3] = '{9000, 100, 100, 8192, 4096, 0, 356, 15, 99,  8194};
      vec[4] = '{1,    200, 100, 1,    0,    0, 200, 0,  200, 3};

      rst = 1'b1; i_load = 1'b0; i_num_words = '0; i_base_addr = '0;
      i_vld = 1'b0; i_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetStrobes", longint'({o_ena, o_wea, o_addra}), 0);
      checkOutput("resetDataZero", longint'(o_dia == '0), 1);
      checkOutput("resetCtrl", longint'({o_rdy, o_busy, o_done, o_start}), 0);
      rst = 1'b0;

      for (int t = 0; t < 5; t++) begin
         applyStimulus(vec[t].numWords, vec[t].base, vec[t].vldPct, -1, lat);
         repeat (2) @(posedge clk);
         #1;
         sz  = writeLog.size();
         bad = 0;
         for (int i = 0; i < sz && i < vec[t].expWrites; i++) begin
            if (writeLog[i].bank != i % NUM_BANK ||
                writeLog[i].addr != (vec[t].base + i / NUM_BANK) % 512 ||
                writeLog[i].data !== wordData(i)) bad++;
         end
         checkOutput($sformatf("job%0d.writes", t), sz, vec[t].expWrites);
         checkOutput($sformatf("job%0d.orderErrors", t), bad, 0);
         checkOutput($sformatf("job%0d.strobeShape", t), strobeErrors, 0);
         checkOutput($sformatf("job%0d.probeBank", t),
                     (vec[t].probeIdx < sz) ? writeLog[vec[t].probeIdx].bank : -1, vec[t].probeBank);
         checkOutput($sformatf("job%0d.probeAddr", t),
                     (vec[t].probeIdx < sz) ? writeLog[vec[t].probeIdx].addr : -1, vec[t].probeAddr);
         checkOutput($sformatf("job%0d.lastBank", t), (sz > 0) ? writeLog[sz-1].bank : -1, vec[t].lastBank);
         checkOutput($sformatf("job%0d.lastAddr", t), (sz > 0) ? writeLog[sz-1].addr : -1, vec[t].lastAddr);
         if (vec[t].expLatency > 0)
            checkOutput($sformatf("job%0d.startLatency", t), lat, vec[t].expLatency);
         else
            checkOutput($sformatf("job%0d.startSeen", t), longint'(lat > 0), 1);
      end

      // Empty job: done/start two cycles after i_load, no writes.
      writeLog.delete();
      @(posedge clk); #1;
      i_load = 1'b1; i_num_words = '0; i_base_addr = AW'(3);
      seen = -1; starts = 0; skew = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         i_load = 1'b0;
         if (o_start && seen < 0) seen = c;
         if (o_start) starts++;
         if (o_start != o_done) skew++;
      end
      checkOutput("emptyStartLatency", seen, 2);
      checkOutput("emptyStartCount", starts, 1);
      checkOutput("emptyDoneSkew", skew, 0);
      checkOutput("emptyWrites", writeLog.size(), 0);

      // Reset mid-job, with a simultaneous i_load that must lose.
      writeLog.delete();
      @(posedge clk); #1;
      i_load = 1'b1; i_num_words = CW'(32); i_base_addr = '0;
      @(posedge clk); #1;
      i_load = 1'b0;
      for (int k = 0; k < 10; k++) begin
         i_vld = 1'b1; i_data = wordData(k);
         @(posedge clk); #1;
      end
      rst = 1'b1; i_load = 1'b1; i_vld = 1'b1;
      @(posedge clk); #1;
      checkOutput("midResetStrobes", longint'({o_ena, o_wea, o_addra}), 0);
      checkOutput("midResetDataZero", longint'(o_dia == '0), 1);
      checkOutput("midResetCtrl", longint'({o_rdy, o_busy, o_done, o_start}), 0);
      rst = 1'b0; i_load = 1'b0; i_vld = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (o_done || o_start || o_busy) seen++;
      end
      checkOutput("midResetPartialWrites", writeLog.size(), 10);
      checkOutput("noDoneAfterReset", seen, 0);
      applyStimulus(4, 0, 100, -1, lat);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("restartWrites", writeLog.size(), 4);
      checkOutput("restartFirstBank", (writeLog.size() > 0) ? writeLog[0].bank : -1, 0);
      checkOutput("restartFirstData",
                  (writeLog.size() > 0) ? longint'(writeLog[0].data === wordData(0)) : 0, 1);

      // i_vld in IDLE is neither accepted nor written.
      writeLog.delete();
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         i_vld = 1'b1; i_data = wordData(1000 + c);
         if (o_rdy) seen++;
      end
      @(posedge clk); #1;
      i_vld = 1'b0;
      checkOutput("idleRdy", seen, 0);
      checkOutput("idleWrites", writeLog.size(), 0);
      applyStimulus(2, 50, 100, -1, lat);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("afterIdleLatency", lat, 4);
      checkOutput("afterIdleFirstData",
                  (writeLog.size() > 0) ? longint'(writeLog[0].data === wordData(0)) : 0, 1);

      // i_load pulsed mid-LOAD must not alter the running job.
      applyStimulus(16, 0, 100, 5, lat);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ignoredLoadWrites", writeLog.size(), 16);
      checkOutput("ignoredLoadLatency", lat, 18);
      checkOutput("ignoredLoadLastAddr", (writeLog.size() > 0) ? writeLog[writeLog.size()-1].addr : -1, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
